// File: rtl/slurm16_periph_pkg.sv
// Shared definitions for slurm16 bus peripherals: register map, STATUS layout
// and the UART serialiser state encoding.
package slurm16_periph_pkg;

   localparam logic [1:0] RegData   = 2'd0;
   localparam logic [1:0] RegStatus = 2'd1;
   localparam logic [1:0] RegBaud   = 2'd2;

   localparam int unsigned StatusFullBit    = 0;
   localparam int unsigned StatusEmptyBit   = 1;
   localparam int unsigned StatusActiveBit  = 2;
   localparam int unsigned StatusCountLsb   = 11;
   localparam int unsigned StatusCountWidth = 5;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} ser_state_e;

   // A zero divisor would give a one-clock bit; the line runs at two clocks instead.
   function automatic logic [15:0] clamp_divisor(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate occupancy counter; push and pop may occur in
// the same cycle, including when full.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

   assign rdata = mem[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter on the slurm16 bus: register decode, write
// stall on a full FIFO, programmable baud down-counter and the serialiser FSM.
module uart_tx_peripheral
   import slurm16_periph_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 10000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned BITS       = 16
) (
   input  logic            CLK,
   input  logic            RSTb,
   input  logic            SEL,
   input  logic [1:0]      ADDRESS,
   input  logic [BITS-1:0] DATA_IN,
   output logic [BITS-1:0] DATA_OUT,
   input  logic            memWR,
   input  logic            memRD,
   output logic            memBUSY,
   output logic            TX
);

   localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
   localparam logic [15:0] ResetBaud = 16'(CLOCK_FREQ / BAUD_RATE - 1);

   logic            wr_en, rd_en, data_wr;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]      fifo_rdata;
   logic [CW-1:0]   fifo_count;
   logic [15:0]     baud_q, baud_cnt_q, divisor;
   ser_state_e      state_q;
   logic [7:0]      shift_q;
   logic [2:0]      bit_cnt_q;
   logic            tx_q;
   logic            bit_end;
   logic [BITS-1:0] rd_data, data_out_q;

   // Write wins over a simultaneous read; the read then returns zero.
   assign wr_en     = SEL & memWR;
   assign rd_en     = SEL & memRD & ~memWR;
   assign data_wr   = wr_en & (ADDRESS == RegData);
   assign fifo_pop  = (state_q == StIdle) & ~fifo_empty;
   assign fifo_push = data_wr & (~fifo_full | fifo_pop);
   assign memBUSY   = data_wr & fifo_full & ~fifo_pop;
   assign divisor   = clamp_divisor(baud_q);
   assign bit_end   = (baud_cnt_q == 16'd0);

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (CLK),
      .rst_n(RSTb),
      .push (fifo_push),
      .pop  (fifo_pop),
      .wdata(DATA_IN[7:0]),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   always_comb begin
      rd_data = '0;
      case (ADDRESS)
         RegStatus: begin
            rd_data[StatusCountLsb +: StatusCountWidth] = StatusCountWidth'(fifo_count);
            rd_data[StatusActiveBit] = (state_q != StIdle);
            rd_data[StatusEmptyBit]  = fifo_empty;
            rd_data[StatusFullBit]   = fifo_full;
         end
         RegBaud: rd_data[15:0] = baud_q;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         baud_q     <= ResetBaud;
         data_out_q <= '0;
      end else begin
         if (wr_en && ADDRESS == RegBaud) baud_q <= DATA_IN[15:0];
         data_out_q <= rd_en ? rd_data : '0;
      end
   end

   // The counter reloads from the live divisor at each bit boundary, so a BAUD
   // write lands on the next bit rather than stretching the current one.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         state_q    <= StIdle;
         tx_q       <= 1'b1;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (!fifo_empty) begin
                  shift_q    <= fifo_rdata;
                  baud_cnt_q <= divisor;
                  tx_q       <= 1'b0;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               if (bit_end) begin
                  baud_cnt_q <= divisor;
                  bit_cnt_q  <= '0;
                  tx_q       <= shift_q[0];
                  state_q    <= StData;
               end else begin
                  baud_cnt_q <= baud_cnt_q - 16'd1;
               end
            end
            StData: begin
               if (bit_end) begin
                  baud_cnt_q <= divisor;
                  if (bit_cnt_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     shift_q   <= {1'b0, shift_q[7:1]};
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q - 16'd1;
               end
            end
            StStop: begin
               if (bit_end) begin
                  state_q <= StIdle;
               end else begin
                  baud_cnt_q <= baud_cnt_q - 16'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign TX       = tx_q;
   assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Bench for uart_tx_peripheral: TX is logged every clock and frames are decoded
// from that log against bytes and bit widths predicted from the register rules.
module tb_uart_tx_peripheral;

   localparam int unsigned ClockFreq = 10000000;
   localparam int unsigned BaudRate  = 115200;
   localparam logic [15:0] ResetBaud = 16'(ClockFreq / BaudRate - 1);

   logic        CLK = 1'b0;
   logic        RSTb = 1'b1;
   logic        SEL = 1'b0;
   logic        memWR = 1'b0;
   logic        memRD = 1'b0;
   logic [1:0]  ADDRESS = 2'd0;
   logic [15:0] DATA_IN = 16'd0;
   logic [15:0] DATA_OUT;
   logic        memBUSY;
   logic        TX;

   int n_checks = 0;
   int n_pass   = 0;
   logic txlog[$];

   uart_tx_peripheral #(
      .CLOCK_FREQ(ClockFreq),
      .BAUD_RATE (BaudRate),
      .FIFO_DEPTH(16),
      .BITS      (16)
   ) dut (
      .CLK     (CLK),
      .RSTb    (RSTb),
      .SEL     (SEL),
      .ADDRESS (ADDRESS),
      .DATA_IN (DATA_IN),
      .DATA_OUT(DATA_OUT),
      .memWR   (memWR),
      .memRD   (memRD),
      .memBUSY (memBUSY),
      .TX      (TX)
   );

   always #5 CLK = ~CLK;
   always @(negedge CLK) txlog.push_back(TX);

   // All bus tasks start and end 1 time unit after a rising edge.
   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d, output int stall);
      SEL = 1'b1; memWR = 1'b1; ADDRESS = a; DATA_IN = d; stall = 0;
      #1;
      while (memBUSY === 1'b1 && stall < 2000) begin
         @(posedge CLK);
         #1;
         stall++;
      end
      @(posedge CLK);
      #1;
      SEL = 1'b0; memWR = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
      SEL = 1'b1; memRD = 1'b1; ADDRESS = a;
      @(posedge CLK);
      #1;
      SEL = 1'b0; memRD = 1'b0;
      d = DATA_OUT;
   endtask

   task automatic wait_tx_low(output logic found);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (TX === 1'b0) begin
            found = 1'b1;
            break;
         end
         @(posedge CLK);
         #1;
      end
   endtask

   function automatic int find_zero(input int from);
      for (int i = from; i < txlog.size(); i++) begin
         if (txlog[i] === 1'b0) return i;
      end
      return -1;
   endfunction

   // Start bit p0 clocks wide, then 8 data bits and a stop bit each p clocks wide.
   function automatic logic decode(input int s, input int p0, input int p,
                                   output logic [7:0] b);
      int   idx;
      logic ok;
      ok = 1'b1;
      b  = '0;
      if (s < 0 || s + p0 + 9 * p > txlog.size()) return 1'b0;
      for (int j = 0; j < p0; j++) if (txlog[s + j] !== 1'b0) ok = 1'b0;
      idx = s + p0;
      for (int k = 0; k < 8; k++) begin
         b[k] = txlog[idx];
         for (int j = 0; j < p; j++) if (txlog[idx + j] !== b[k]) ok = 1'b0;
         idx += p;
      end
      for (int j = 0; j < p; j++) if (txlog[idx + j] !== 1'b1) ok = 1'b0;
      return ok;
   endfunction

   task automatic test_reset();
      logic [15:0] d;
      #2 RSTb = 1'b0;
      #1;
      n_checks++; if (TX !== 1'b1) $display("FAIL rst_tx got %b want 1", TX); else n_pass++;
      n_checks++; if (memBUSY !== 1'b0) $display("FAIL rst_busy got %b want 0", memBUSY); else n_pass++;
      n_checks++; if (DATA_OUT !== 16'h0) $display("FAIL rst_dout got %h want 0000", DATA_OUT); else n_pass++;
      repeat (3) @(posedge CLK);
      #3 RSTb = 1'b1;
      cycles(1);
      bus_read(2'd1, d);
      n_checks++; if (d !== 16'h0002) $display("FAIL rst_status got %h want 0002", d); else n_pass++;
      n_checks++; if (TX !== 1'b1) $display("FAIL rst_tx_idle got %b want 1", TX); else n_pass++;
      bus_read(2'd2, d);
      n_checks++; if (d !== ResetBaud) $display("FAIL rst_baud got %h want %h", d, ResetBaud); else n_pass++;
      bus_read(2'd0, d);
      n_checks++; if (d !== 16'h0) $display("FAIL rd_data_reg got %h want 0000", d); else n_pass++;
      bus_read(2'd3, d);
      n_checks++; if (d !== 16'h0) $display("FAIL rd_reserved got %h want 0000", d); else n_pass++;
   endtask

   task automatic test_basic_frame();
      int st, s;
      logic [15:0] d;
      logic [7:0] b;
      logic ok;
      bus_write(2'd2, 16'd3, st);
      txlog.delete();
      bus_write(2'd0, 16'h01A5, st);
      cycles(2);
      bus_read(2'd1, d);
      n_checks++; if (d !== 16'h0006) $display("FAIL frame_status got %h want 0006", d); else n_pass++;
      cycles(60);
      s  = find_zero(0);
      ok = decode(s, 4, 4, b);
      n_checks++; if (ok !== 1'b1) $display("FAIL frame_shape got %b want 1 (start %0d)", ok, s); else n_pass++;
      n_checks++; if (b !== 8'hA5) $display("FAIL frame_byte got %h want a5", b); else n_pass++;
      n_checks++; if (find_zero(s + 40) != -1) $display("FAIL frame_len got extra low at %0d want none", find_zero(s + 40)); else n_pass++;
      bus_read(2'd1, d);
      n_checks++; if (d !== 16'h0002) $display("FAIL frame_done_status got %h want 0002", d); else n_pass++;
   endtask

   task automatic test_baud_zero();
      int st, s;
      logic [7:0] b;
      logic ok;
      bus_write(2'd2, 16'd0, st);
      txlog.delete();
      bus_write(2'd0, 16'h0055, st);
      cycles(40);
      s  = find_zero(0);
      ok = decode(s, 2, 2, b);
      n_checks++; if (ok !== 1'b1) $display("FAIL baud0_shape got %b want 1", ok); else n_pass++;
      n_checks++; if (b !== 8'h55) $display("FAIL baud0_byte got %h want 55", b); else n_pass++;
      n_checks++; if (find_zero(s + 20) != -1) $display("FAIL baud0_len got extra low want none"); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int st, tot, s, prev, nbad;
      logic [15:0] d;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      logic ok;
      bus_write(2'd2, 16'd3, st);
      txlog.delete();
      exp_q.push_back(8'hEE);
      bus_write(2'd0, 16'h00EE, st);
      tot = 0;
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(8'(k));
         bus_write(2'd0, 16'(k), st);
         tot += st;
      end
      n_checks++; if (tot != 0) $display("FAIL b2b_fill_stall got %0d want 0", tot); else n_pass++;
      exp_q.push_back(8'h10);
      bus_write(2'd0, 16'h0010, st);
      // Accepted at the pop after the 0xEE frame: 1 pop + 40 frame + 1 idle, vs. 17 unstalled.
      n_checks++; if (st != 1 + 10 * 4 + 1 - 17) $display("FAIL b2b_stall got %0d want %0d", st, 1 + 10 * 4 + 1 - 17); else n_pass++;
      bus_read(2'd1, d);
      n_checks++; if (d !== 16'h8005) $display("FAIL b2b_full_status got %h want 8005", d); else n_pass++;
      cycles(18 * 41 + 20);
      s = find_zero(0);
      prev = s;
      nbad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         ok = decode(s, 4, 4, b);
         n_checks++;
         if (ok !== 1'b1 || b !== exp_q[i]) begin
            $display("FAIL b2b_frame%0d got %h ok=%b want %h", i, b, ok, exp_q[i]);
            nbad++;
         end else n_pass++;
         if (i > 0) begin
            n_checks++; if (s - prev != 41) $display("FAIL b2b_gap%0d got %0d want 41", i, s - prev); else n_pass++;
         end
         prev = s;
         s = find_zero(s + 40);
         if (nbad > 3 || s < 0) break;
      end
      n_checks++; if (find_zero(prev + 40) != -1) $display("FAIL b2b_extra got low after last frame want none"); else n_pass++;
   endtask

   task automatic test_bus_decode();
      int st;
      logic [15:0] d, v;
      bus_write(2'd2, 16'd3, st);
      txlog.delete();
      bus_write(2'd1, 16'($urandom), st);
      n_checks++; if (st != 0) $display("FAIL wr_status_stall got %0d want 0", st); else n_pass++;
      bus_write(2'd3, 16'($urandom), st);
      n_checks++; if (st != 0) $display("FAIL wr_reserved_stall got %0d want 0", st); else n_pass++;
      bus_read(2'd2, d);
      n_checks++; if (d !== 16'd3) $display("FAIL baud_kept got %h want 0003", d); else n_pass++;
      v = 16'($urandom_range(4, 65535));
      SEL = 1'b1; memRD = 1'b1; memWR = 1'b1; ADDRESS = 2'd2; DATA_IN = v;
      cycles(1);
      SEL = 1'b0; memRD = 1'b0; memWR = 1'b0;
      n_checks++; if (DATA_OUT !== 16'h0) $display("FAIL rdwr_dout got %h want 0000", DATA_OUT); else n_pass++;
      bus_read(2'd2, d);
      n_checks++; if (d !== v) $display("FAIL rdwr_baud got %h want %h", d, v); else n_pass++;
      n_checks++; if (find_zero(0) != -1) $display("FAIL decode_no_frame got low TX want none"); else n_pass++;
      bus_write(2'd2, 16'd3, st);
   endtask

   task automatic test_random_frames();
      int st, s, prev, baud, p, n;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      logic ok;
      for (int r = 0; r < 3; r++) begin
         baud = $urandom_range(0, 5);
         p    = ((baud == 0) ? 1 : baud) + 1;
         n    = $urandom_range(2, 5);
         exp_q.delete();
         bus_write(2'd2, 16'(baud), st);
         txlog.delete();
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(2'd0, {8'($urandom), b}, st);
         end
         cycles(n * (10 * p + 1) + 20);
         s = find_zero(0);
         prev = s;
         for (int i = 0; i < n; i++) begin
            ok = decode(s, p, p, b);
            n_checks++;
            if (ok !== 1'b1 || b !== exp_q[i])
               $display("FAIL rnd%0d_frame%0d got %h ok=%b want %h (p=%0d)", r, i, b, ok, exp_q[i], p);
            else n_pass++;
            if (i > 0) begin
               n_checks++; if (s - prev != 10 * p + 1) $display("FAIL rnd%0d_gap%0d got %0d want %0d", r, i, s - prev, 10 * p + 1); else n_pass++;
            end
            prev = s;
            s = find_zero(s + 10 * p);
            if (s < 0) break;
         end
         n_checks++; if (find_zero(prev + 10 * p) != -1) $display("FAIL rnd%0d_extra got low after last frame want none", r); else n_pass++;
      end
   endtask

   task automatic test_baud_midframe();
      int st, s;
      logic [7:0] b, b0;
      logic ok, found;
      bus_write(2'd2, 16'd3, st);
      txlog.delete();
      b0 = 8'($urandom) | 8'h01;
      bus_write(2'd0, {8'($urandom), b0}, st);
      wait_tx_low(found);
      n_checks++; if (found !== 1'b1) $display("FAIL mid_baud_start got no start bit want one"); else n_pass++;
      bus_write(2'd2, 16'd7, st);
      cycles(100);
      s  = find_zero(0);
      ok = decode(s, 4, 8, b);
      n_checks++; if (ok !== 1'b1) $display("FAIL mid_baud_shape got %b want 1", ok); else n_pass++;
      n_checks++; if (b !== b0) $display("FAIL mid_baud_byte got %h want %h", b, b0); else n_pass++;
      n_checks++; if (find_zero(s + 4 + 72) != -1) $display("FAIL mid_baud_len got extra low want none"); else n_pass++;
      bus_write(2'd2, 16'd3, st);
   endtask

   task automatic test_reset_midframe();
      int st;
      logic [15:0] d;
      logic found;
      bus_write(2'd2, 16'd3, st);
      bus_write(2'd0, 16'h00FF, st);
      bus_write(2'd0, 16'h0081, st);
      wait_tx_low(found);
      n_checks++; if (found !== 1'b1) $display("FAIL rstmid_start got no start bit want one"); else n_pass++;
      cycles(17);
      #2 RSTb = 1'b0;
      #1;
      n_checks++; if (TX !== 1'b1) $display("FAIL rstmid_tx got %b want 1", TX); else n_pass++;
      n_checks++; if (memBUSY !== 1'b0) $display("FAIL rstmid_busy got %b want 0", memBUSY); else n_pass++;
      @(posedge CLK);
      #3 RSTb = 1'b1;
      cycles(1);
      bus_write(2'd2, 16'd3, st);
      bus_write(2'd0, 16'h0000, st);
      wait_tx_low(found);
      n_checks++; if (found !== 1'b1) $display("FAIL rststart_start got no start bit want one"); else n_pass++;
      #2 RSTb = 1'b0;
      #1;
      n_checks++; if (TX !== 1'b1) $display("FAIL rststart_tx got %b want 1", TX); else n_pass++;
      @(posedge CLK);
      #3 RSTb = 1'b1;
      cycles(1);
      txlog.delete();
      cycles(300);
      n_checks++; if (find_zero(0) != -1) $display("FAIL rstmid_resume got low TX want none"); else n_pass++;
      bus_read(2'd1, d);
      n_checks++; if (d !== 16'h0002) $display("FAIL rstmid_status got %h want 0002", d); else n_pass++;
      bus_read(2'd2, d);
      n_checks++; if (d !== ResetBaud) $display("FAIL rstmid_baud got %h want %h", d, ResetBaud); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_baud_zero();
      test_back_to_back();
      test_bus_decode();
      test_random_frames();
      test_baud_midframe();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
